// File: rtl/branch_resolve_id_pkg.sv
// Shared opcode/funct constants and ID-stage resolver state encoding.
package branch_resolve_id_pkg;

   localparam logic [5:0] OP_SPECIAL   = 6'h00;
   localparam logic [5:0] OP_BLTZ_BGEZ = 6'h01;
   localparam logic [5:0] OP_BEQ       = 6'h04;
   localparam logic [5:0] OP_BNE       = 6'h05;
   localparam logic [5:0] OP_BLEZ      = 6'h06;
   localparam logic [5:0] OP_BGTZ      = 6'h07;
   localparam logic [5:0] FUNCT_JR     = 6'h08;
   localparam logic [5:0] FUNCT_JALR   = 6'h09;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      PEND = 2'd2
   } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational conditional-branch decode and signed condition evaluation.
module branch_cond_eval
   import branch_resolve_id_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [4:0]  rt,
   input  logic [31:0] rsv,
   input  logic [31:0] rtv,
   output logic        is_branch,
   output logic        taken
);

   always_comb begin
      is_branch = 1'b0;
      taken     = 1'b0;
      case (op)
         OP_BEQ: begin
            is_branch = 1'b1;
            taken     = (rsv == rtv);
         end
         OP_BNE: begin
            is_branch = 1'b1;
            taken     = (rsv != rtv);
         end
         OP_BLEZ: begin
            if (rt == 5'd0) begin
               is_branch = 1'b1;
               taken     = ($signed(rsv) <= 32'sd0);
            end
         end
         OP_BGTZ: begin
            if (rt == 5'd0) begin
               is_branch = 1'b1;
               taken     = ($signed(rsv) > 32'sd0);
            end
         end
         OP_BLTZ_BGEZ: begin
            // rt selects the variant: 0 = BLTZ, 1 = BGEZ
            if (rt == 5'd0) begin
               is_branch = 1'b1;
               taken     = ($signed(rsv) < 32'sd0);
            end else if (rt == 5'd1) begin
               is_branch = 1'b1;
               taken     = ($signed(rsv) >= 32'sd0);
            end
         end
         default: begin
            is_branch = 1'b0;
            taken     = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/branch_resolve_id.sv
// ID-stage IF/ID register with branch/jr resolution and redirect/flush back to IF.
// Optional statistics counters enabled by defining BRANCH_STATS_EN.
module branch_resolve_id
   import branch_resolve_id_pkg::*;
#(
   parameter logic [31:0] MAX_INSADDR = 32'hffff_fff8,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [31:0]      IF_PC,
   input  logic [31:0]      IF_INS,
   input  logic             IF_pred_taken,
   input  logic [31:0]      rsv,
   input  logic [31:0]      rtv,
   input  logic             opnd_ready,
   output logic [31:0]      ID_PC,
   output logic [31:0]      ID_INS,
   output logic             ID_valid,
   output logic             ID_branch_ins,
   output logic             ID_branch_taken,
   output logic             ID_jr_ins,
   output logic             redirect,
   output logic [31:0]      redirect_addr,
   output logic             stall_req,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_ins_q, id_ins_d;
   logic        id_pred_q, id_pred_d;
   logic        id_valid_q, id_valid_d;
   state_t      state_q, state_d;
   logic [31:0] pend_addr_q, pend_addr_d;

   logic [5:0]  op, funct;
   logic [4:0]  rt, rd, shamt;
   logic [15:0] imm;
   logic        br_raw, taken_raw;
   logic        is_br, is_jr;
   logic [31:0] fallthrough, target;

   assign op    = id_ins_q[31:26];
   assign rt    = id_ins_q[20:16];
   assign rd    = id_ins_q[15:11];
   assign shamt = id_ins_q[10:6];
   assign funct = id_ins_q[5:0];
   assign imm   = id_ins_q[15:0];

   branch_cond_eval u_cond (
      .op        (op),
      .rt        (rt),
      .rsv       (rsv),
      .rtv       (rtv),
      .is_branch (br_raw),
      .taken     (taken_raw)
   );

   assign is_br = id_valid_q & br_raw;
   assign is_jr = id_valid_q & (op == OP_SPECIAL) & (rt == 5'd0) & (shamt == 5'd0) &
                  (((funct == FUNCT_JR) & (rd == 5'd0)) | (funct == FUNCT_JALR));

   assign fallthrough = (id_pc_q < MAX_INSADDR) ? id_pc_q + 32'd4 : id_pc_q;
   assign target      = id_pc_q + 32'd4 + {{14{imm[15]}}, imm, 2'b00};

   always_comb begin
      state_d       = state_q;
      pend_addr_d   = pend_addr_q;
      stall_req     = 1'b0;
      redirect      = 1'b0;
      redirect_addr = '0;
      case (state_q)
         RUN, WAIT: begin
            if (is_br || is_jr) begin
               if (!opnd_ready) begin
                  stall_req = 1'b1;
                  state_d   = WAIT;
               end else begin
                  state_d = RUN;
                  if (is_jr) begin
                     redirect      = 1'b1;
                     redirect_addr = rsv;
                  end else begin
                     redirect      = (taken_raw != id_pred_q);
                     redirect_addr = taken_raw ? target : fallthrough;
                  end
                  // a redirect blocked by stall is parked so it survives operand changes
                  if (redirect && stall) begin
                     state_d     = PEND;
                     pend_addr_d = redirect_addr;
                  end
               end
            end else begin
               state_d = RUN;
            end
         end
         PEND: begin
            redirect      = 1'b1;
            redirect_addr = pend_addr_q;
            if (!stall) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      id_pc_d    = id_pc_q;
      id_ins_d   = id_ins_q;
      id_pred_d  = id_pred_q;
      id_valid_d = id_valid_q;
      if (!stall) begin
         id_pc_d = IF_PC;
         if (redirect) begin
            id_ins_d   = '0;
            id_pred_d  = 1'b0;
            id_valid_d = 1'b0;
         end else begin
            id_ins_d   = IF_INS;
            id_pred_d  = IF_pred_taken;
            id_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_pc_q     <= '0;
         id_ins_q    <= '0;
         id_pred_q   <= 1'b0;
         id_valid_q  <= 1'b0;
         state_q     <= RUN;
         pend_addr_q <= '0;
      end else begin
         id_pc_q     <= id_pc_d;
         id_ins_q    <= id_ins_d;
         id_pred_q   <= id_pred_d;
         id_valid_q  <= id_valid_d;
         state_q     <= state_d;
         pend_addr_q <= pend_addr_d;
      end
   end

   assign ID_PC           = id_pc_q;
   assign ID_INS          = id_ins_q;
   assign ID_valid        = id_valid_q;
   assign ID_branch_ins   = is_br;
   assign ID_branch_taken = is_br & taken_raw;
   assign ID_jr_ins       = is_jr;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
   logic             pend_br_q, pend_br_d;
   logic             br_inc, mis_inc;

   always_comb begin
      br_inc    = 1'b0;
      mis_inc   = 1'b0;
      pend_br_d = pend_br_q;
      if (state_q == PEND) begin
         br_inc  = !stall && pend_br_q;
         mis_inc = !stall && pend_br_q;
      end else begin
         // a stalled branch stays in ID and is counted when it finally advances
         br_inc  = is_br && opnd_ready && !stall;
         mis_inc = is_br && opnd_ready && !stall && redirect;
         if (state_d == PEND) pend_br_d = is_br;
      end
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (br_inc && (branch_cnt_q != '1))      branch_cnt_d     = branch_cnt_q + 1'b1;
      if (mis_inc && (mispredict_cnt_q != '1)) mispredict_cnt_d = mispredict_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
         pend_br_q        <= 1'b0;
      end else begin
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
         pend_br_q        <= pend_br_d;
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;
`else
   assign branch_cnt     = '0;
   assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_id.sv
// Directed self-checking bench for branch_resolve_id.
module tb_branch_resolve_id;

   localparam logic [31:0] MAXA = 32'hffff_fff8;
`ifdef BRANCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic [31:0] IF_PC = '0, IF_INS = '0, rsv = '0, rtv = '0;
   logic        IF_pred_taken = 1'b0, opnd_ready = 1'b0;
   logic [31:0] ID_PC, ID_INS, redirect_addr;
   logic        ID_valid, ID_branch_ins, ID_branch_taken, ID_jr_ins, redirect, stall_req;
   logic [15:0] branch_cnt, mispredict_cnt;

   int n_vec = 0;
   int n_err = 0;
   int exp_br = 0;
   int exp_mis = 0;

   branch_resolve_id #(.MAX_INSADDR(MAXA), .CNT_W(16)) dut (
      .clk(clk), .rst(rst_n), .stall(stall), .IF_PC(IF_PC), .IF_INS(IF_INS),
      .IF_pred_taken(IF_pred_taken), .rsv(rsv), .rtv(rtv), .opnd_ready(opnd_ready),
      .ID_PC(ID_PC), .ID_INS(ID_INS), .ID_valid(ID_valid), .ID_branch_ins(ID_branch_ins),
      .ID_branch_taken(ID_branch_taken), .ID_jr_ins(ID_jr_ins), .redirect(redirect),
      .redirect_addr(redirect_addr), .stall_req(stall_req), .branch_cnt(branch_cnt),
      .mispredict_cnt(mispredict_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [15:0] cexp(input int n);
      return STATS ? n[15:0] : 16'd0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // puts an instruction into ID with IF then presenting a plain nop stream
   task automatic load(input logic [31:0] pc, input logic [31:0] ins, input logic pred);
      stall = 1'b0; IF_PC = pc; IF_INS = ins; IF_pred_taken = pred;
      step();
      IF_PC = pc + 32'd4; IF_INS = 32'h2000_0000; IF_pred_taken = 1'b0;
   endtask

   task automatic test_reset();
      IF_PC = 32'h1234; IF_INS = 32'h1000_0001; IF_pred_taken = 1'b1;
      #12;
      n_vec++; if (ID_PC !== 32'd0) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", ID_PC, 32'd0); end
      n_vec++; if (ID_INS !== 32'd0) begin n_err++; $display("FAIL reset_ins got=%h exp=%h", ID_INS, 32'd0); end
      n_vec++; if (ID_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", ID_valid); end
      n_vec++; if ({redirect, stall_req, ID_branch_ins, ID_jr_ins} !== 4'b0) begin
         n_err++; $display("FAIL reset_ctl got=%b exp=0000", {redirect, stall_req, ID_branch_ins, ID_jr_ins}); end
      n_vec++; if ({branch_cnt, mispredict_cnt} !== 32'd0) begin
         n_err++; $display("FAIL reset_cnt got=%h exp=0", {branch_cnt, mispredict_cnt}); end
      @(negedge clk); rst_n = 1'b1;
      step();
   endtask

   task automatic test_beq_taken();
      load(32'h100, enc_i(6'h04, 5'd1, 5'd2, 16'd4), 1'b0);
      rsv = 32'd5; rtv = 32'd5; opnd_ready = 1'b1; IF_INS = 32'h2000_0007;
      #1;
      n_vec++; if ({ID_branch_ins, ID_branch_taken, redirect} !== 3'b111) begin
         n_err++; $display("FAIL beq_flags got=%b exp=111", {ID_branch_ins, ID_branch_taken, redirect}); end
      n_vec++; if (redirect_addr !== 32'h114) begin n_err++; $display("FAIL beq_addr got=%h exp=%h", redirect_addr, 32'h114); end
      step(); exp_br++; exp_mis++;
      n_vec++; if ({ID_valid, redirect} !== 2'b00) begin n_err++; $display("FAIL beq_flush got=%b exp=00", {ID_valid, redirect}); end
      n_vec++; if (ID_INS !== 32'd0 || ID_PC !== 32'h104) begin
         n_err++; $display("FAIL beq_bubble got=%h/%h exp=0/104", ID_INS, ID_PC); end
      n_vec++; if (mispredict_cnt !== cexp(exp_mis)) begin
         n_err++; $display("FAIL beq_miscnt got=%0d exp=%0d", mispredict_cnt, cexp(exp_mis)); end
   endtask

   task automatic test_bne_fallthrough();
      load(32'h200, enc_i(6'h05, 5'd3, 5'd4, 16'h0040), 1'b1);
      rsv = 32'd7; rtv = 32'd7; opnd_ready = 1'b1;
      #1;
      n_vec++; if ({ID_branch_taken, redirect} !== 2'b01) begin
         n_err++; $display("FAIL bne_flags got=%b exp=01", {ID_branch_taken, redirect}); end
      n_vec++; if (redirect_addr !== 32'h204) begin n_err++; $display("FAIL bne_addr got=%h exp=%h", redirect_addr, 32'h204); end
      step(); exp_br++; exp_mis++;
      n_vec++; if (ID_valid !== 1'b0) begin n_err++; $display("FAIL bne_flush got=%b exp=0", ID_valid); end
   endtask

   task automatic test_bgez_correct();
      load(32'h300, enc_i(6'h01, 5'd2, 5'd1, 16'h0010), 1'b1);
      rsv = 32'd0; opnd_ready = 1'b1;
      #1;
      n_vec++; if ({ID_branch_ins, ID_branch_taken, redirect} !== 3'b110) begin
         n_err++; $display("FAIL bgez_flags got=%b exp=110", {ID_branch_ins, ID_branch_taken, redirect}); end
      step(); exp_br++;
      n_vec++; if (ID_valid !== 1'b1 || ID_PC !== 32'h304) begin
         n_err++; $display("FAIL bgez_advance got=%b/%h exp=1/304", ID_valid, ID_PC); end
      n_vec++; if (branch_cnt !== cexp(exp_br)) begin
         n_err++; $display("FAIL bgez_brcnt got=%0d exp=%0d", branch_cnt, cexp(exp_br)); end
   endtask

   task automatic test_jr_wait();
      load(32'h40, {6'h00, 5'd5, 5'd0, 5'd0, 5'd0, 6'h08}, 1'b0);
      opnd_ready = 1'b0; stall = 1'b1; rsv = 32'hdead_0000;
      #1;
      n_vec++; if ({ID_jr_ins, stall_req, redirect} !== 3'b110) begin
         n_err++; $display("FAIL jr_wait1 got=%b exp=110", {ID_jr_ins, stall_req, redirect}); end
      step();
      n_vec++; if ({stall_req, redirect} !== 2'b10 || ID_PC !== 32'h40) begin
         n_err++; $display("FAIL jr_wait2 got=%b/%h exp=10/40", {stall_req, redirect}, ID_PC); end
      step();
      opnd_ready = 1'b1; rsv = 32'h800; stall = 1'b0;
      #1;
      n_vec++; if ({stall_req, redirect} !== 2'b01) begin
         n_err++; $display("FAIL jr_ready got=%b exp=01", {stall_req, redirect}); end
      n_vec++; if (redirect_addr !== 32'h800) begin n_err++; $display("FAIL jr_addr got=%h exp=%h", redirect_addr, 32'h800); end
      step();
      n_vec++; if ({ID_valid, stall_req, redirect} !== 3'b000) begin
         n_err++; $display("FAIL jr_flush got=%b exp=000", {ID_valid, stall_req, redirect}); end
   endtask

   task automatic test_pend_stall();
      load(32'h500, enc_i(6'h01, 5'd6, 5'd0, 16'hfffe), 1'b0);
      rsv = 32'hffff_ffff; opnd_ready = 1'b1; stall = 1'b1;
      #1;
      n_vec++; if (redirect !== 1'b1 || redirect_addr !== 32'h4fc) begin
         n_err++; $display("FAIL pend_enter got=%b/%h exp=1/4fc", redirect, redirect_addr); end
      for (int c = 0; c < 2; c++) begin
         step();
         rsv = 32'd5;
         #1;
         n_vec++; if (redirect !== 1'b1 || redirect_addr !== 32'h4fc || ID_PC !== 32'h500) begin
            n_err++; $display("FAIL pend_hold%0d got=%b/%h/%h exp=1/4fc/500", c, redirect, redirect_addr, ID_PC); end
      end
      stall = 1'b0;
      #1;
      n_vec++; if (redirect !== 1'b1 || redirect_addr !== 32'h4fc) begin
         n_err++; $display("FAIL pend_release got=%b/%h exp=1/4fc", redirect, redirect_addr); end
      step(); exp_br++; exp_mis++;
      n_vec++; if ({ID_valid, redirect} !== 2'b00 || ID_PC !== 32'h504) begin
         n_err++; $display("FAIL pend_flush got=%b/%h exp=00/504", {ID_valid, redirect}, ID_PC); end
      n_vec++; if ({branch_cnt, mispredict_cnt} !== {cexp(exp_br), cexp(exp_mis)}) begin
         n_err++; $display("FAIL pend_cnt got=%0d/%0d exp=%0d/%0d", branch_cnt, mispredict_cnt, cexp(exp_br), cexp(exp_mis)); end
   endtask

   task automatic test_max_addr();
      load(MAXA, enc_i(6'h04, 5'd1, 5'd2, 16'h0020), 1'b1);
      rsv = 32'd1; rtv = 32'd2; opnd_ready = 1'b1;
      #1;
      n_vec++; if (redirect !== 1'b1 || redirect_addr !== MAXA) begin
         n_err++; $display("FAIL max_addr got=%b/%h exp=1/%h", redirect, redirect_addr, MAXA); end
      step(); exp_br++; exp_mis++;
      n_vec++; if (mispredict_cnt !== cexp(exp_mis)) begin
         n_err++; $display("FAIL max_miscnt got=%0d exp=%0d", mispredict_cnt, cexp(exp_mis)); end
   endtask

   task automatic test_pend_reset();
      load(32'h600, enc_i(6'h05, 5'd1, 5'd2, 16'd1), 1'b0);
      rsv = 32'd1; rtv = 32'd2; opnd_ready = 1'b1; stall = 1'b1;
      step();
      n_vec++; if (redirect !== 1'b1 || redirect_addr !== 32'h608) begin
         n_err++; $display("FAIL prst_pend got=%b/%h exp=1/608", redirect, redirect_addr); end
      rst_n = 1'b0; exp_br = 0; exp_mis = 0;
      #1;
      n_vec++; if ({redirect, stall_req, ID_valid} !== 3'b000) begin
         n_err++; $display("FAIL prst_ctl got=%b exp=000", {redirect, stall_req, ID_valid}); end
      n_vec++; if ({branch_cnt, mispredict_cnt} !== 32'd0) begin
         n_err++; $display("FAIL prst_cnt got=%h exp=0", {branch_cnt, mispredict_cnt}); end
      @(negedge clk); rst_n = 1'b1;
      step();
      n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL prst_after got=%b exp=0", redirect); end
   endtask

   initial begin
      test_reset();
      test_beq_taken();
      test_bne_fallthrough();
      test_bgez_correct();
      test_jr_wait();
      test_pend_stall();
      test_max_addr();
      test_pend_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
